// File: rtl/bram1_fifo_obuf.sv
// bram1_fifo_obuf
// Two-entry in-order output buffer that sits behind the BRAM read port of
// bram1_fifo_ctrl. Entry 0 is always the head. A capture and a dequeue in the
// same cycle both take effect. The occupancy is reset; the data registers
// are not.
//
// Ports
//   CLK, RST     clock (rising edge), asynchronous active-high reset
//   i_cap        capture i_cap_data this cycle (never asserted when full)
//   i_cap_data   data returning from the BRAM
//   i_deq        consumer takes the head this cycle (ignored when empty)
//   o_valid      buffer holds at least one entry
//   o_data       head entry
//   o_occ        number of entries held (0..2)
module bram1_fifo_obuf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_cap,
  input  logic [DATA_WIDTH-1:0] i_cap_data,
  input  logic                  i_deq,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occ
);

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  w_deq;

  assign w_deq   = i_deq && (r_occ != 2'd0);
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_data0;
  assign o_occ   = r_occ;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_occ <= 2'd0;
    end else begin
      r_occ <= r_occ + {1'b0, i_cap} - {1'b0, w_deq};
    end
  end

  // On a dequeue the head is refilled from entry 1 when two are held,
  // otherwise directly from a simultaneous capture.
  always_ff @(posedge CLK) begin
    if (w_deq) begin
      r_data0 <= (r_occ == 2'd2) ? r_data1 : i_cap_data;
      if (i_cap && (r_occ == 2'd2)) begin
        r_data1 <= i_cap_data;
      end
    end else if (i_cap) begin
      if (r_occ == 2'd0) begin
        r_data0 <= i_cap_data;
      end else begin
        r_data1 <= i_cap_data;
      end
    end
  end

endmodule

// File: rtl/bram1_fifo_ctrl.sv
// bram1_fifo_ctrl
// FIFO controller around an external single-port BRAM (BRAM1) with 1- or
// 2-cycle read latency. One BRAM operation per cycle: a read (refilling the
// output buffer) has priority over a write (enqueue). Reads are only issued
// when an output buffer slot is guaranteed, so returning data never overflows.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   ENQ_VALID/ENQ_DATA/ENQ_READY  producer handshake
//   DEQ_VALID/DEQ_DATA/DEQ_READY  consumer handshake
//   BRAM_EN/WE/ADDR/DI            BRAM1 control and write data
//   BRAM_DO                       BRAM1 read data
//   COUNT                         entries held (memory + in flight + buffer)
module bram1_fifo_ctrl #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MEMSIZE    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENQ_VALID,
  input  logic [DATA_WIDTH-1:0] ENQ_DATA,
  output logic                  ENQ_READY,
  output logic                  DEQ_VALID,
  output logic [DATA_WIDTH-1:0] DEQ_DATA,
  input  logic                  DEQ_READY,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO,
  output logic [ADDR_WIDTH+1:0] COUNT
);

  localparam int                    L        = (PIPELINED != 0) ? 2 : 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEMSIZE - 1);
  localparam logic [ADDR_WIDTH:0]   MEM_FULL = (ADDR_WIDTH + 1)'(MEMSIZE);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_count;
  logic [L-1:0]          r_vld_pipe;
  logic [1:0]            w_inflight;
  logic [1:0]            w_obuf_occ;
  logic                  w_read;
  logic                  w_write;

  // Pointers wrap at MEMSIZE-1, which need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = 2'd0;
    for (int i = 0; i < L; i++) begin
      w_inflight = w_inflight + {1'b0, r_vld_pipe[i]};
    end
  end

  // Buffer slots are reserved at issue time: occupied + in flight < 2.
  assign w_read    = !RST && (r_mem_count != '0) &&
                     (({1'b0, w_obuf_occ} + {1'b0, w_inflight}) < 3'd2);
  assign ENQ_READY = !RST && (r_mem_count < MEM_FULL) && !w_read;
  assign w_write   = ENQ_VALID && ENQ_READY;

  assign BRAM_EN   = w_read || w_write;
  assign BRAM_WE   = w_write;
  assign BRAM_ADDR = w_read ? r_rd_ptr : r_wr_ptr;
  assign BRAM_DI   = ENQ_DATA;

  assign COUNT = {1'b0, r_mem_count}
               + (ADDR_WIDTH + 2)'(w_inflight)
               + (ADDR_WIDTH + 2)'(w_obuf_occ);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_vld_pipe  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_read) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_mem_count <= r_mem_count + {{ADDR_WIDTH{1'b0}}, w_write}
                                 - {{ADDR_WIDTH{1'b0}}, w_read};
      // Clearing this on reset is what discards reads still in flight.
      r_vld_pipe  <= (r_vld_pipe << 1) | L'(w_read);
    end
  end

  bram1_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .CLK        (CLK),
    .RST        (RST),
    .i_cap      (r_vld_pipe[L-1]),
    .i_cap_data (BRAM_DO),
    .i_deq      (DEQ_READY),
    .o_valid    (DEQ_VALID),
    .o_data     (DEQ_DATA),
    .o_occ      (w_obuf_occ)
  );

endmodule

// File: tb/tb_bram1_fifo_ctrl.sv
// Bench for bram1_fifo_ctrl: three instances (MEMSIZE=4/PIPELINED=0,
// MEMSIZE=4/PIPELINED=1, MEMSIZE=3/PIPELINED=0), each with its own BRAM1
// model, checked every cycle against a reference queue plus directed
// scenarios with literal expectations.
module tb_bram1_fifo_ctrl;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ev  [N];
  logic [DW-1:0] ed  [N];
  logic          er  [N];
  logic          dv  [N];
  logic [DW-1:0] dd  [N];
  logic          dr  [N];
  logic          ben [N];
  logic          bwe [N];
  logic [AW-1:0] badr[N];
  logic [DW-1:0] bdi [N];
  logic [DW-1:0] bdo [N];
  logic [AW+1:0] cnt [N];

  int            n_vec  = 0;
  int            n_fail = 0;
  logic [DW-1:0] q [N][$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int MS = (g == 2) ? 3 : 4;
    localparam int PL = (g == 1) ? 1 : 0;
    logic [DW-1:0] mem [16];
    logic [DW-1:0] do1;
    logic [DW-1:0] do2;

    bram1_fifo_ctrl #(
      .PIPELINED (PL), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MEMSIZE (MS)
    ) u_dut (
      .CLK (clk), .RST (rst),
      .ENQ_VALID (ev[g]), .ENQ_DATA (ed[g]), .ENQ_READY (er[g]),
      .DEQ_VALID (dv[g]), .DEQ_DATA (dd[g]), .DEQ_READY (dr[g]),
      .BRAM_EN (ben[g]), .BRAM_WE (bwe[g]), .BRAM_ADDR (badr[g]),
      .BRAM_DI (bdi[g]), .BRAM_DO (bdo[g]), .COUNT (cnt[g])
    );

    always @(posedge clk) begin
      if (ben[g]) begin
        if (bwe[g]) mem[badr[g]] <= bdi[g];
        else        do1 <= mem[badr[g]];
      end
      do2 <= do1;
    end
    assign bdo[g] = (PL == 1) ? do2 : do1;
  end

  function automatic int ms_of(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference queue: what was accepted and not yet consumed.
  task automatic monitor(input int i);
    if (rst) begin
      q[i].delete();
      chk($sformatf("rst_count[%0d]", i), 32'(cnt[i]), 0);
      chk($sformatf("rst_deq_valid[%0d]", i), 32'(dv[i]), 0);
      chk($sformatf("rst_enq_ready[%0d]", i), 32'(er[i]), 0);
      chk($sformatf("rst_bram_en[%0d]", i), 32'(ben[i]), 0);
    end else begin
      chk($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(q[i].size()));
      chk($sformatf("write_iff_enq[%0d]", i), 32'(ben[i] & bwe[i]), 32'(ev[i] & er[i]));
      if (q[i].size() == ms_of(i) + 2)
        chk($sformatf("full_not_ready[%0d]", i), 32'(er[i]), 0);
      if (dv[i])
        chk($sformatf("valid_has_entry[%0d]", i), 32'(q[i].size() > 0), 1);
      if (dv[i] && dr[i] && q[i].size() > 0) begin
        chk($sformatf("deq_data[%0d]", i), 32'(dd[i]), 32'(q[i][0]));
        void'(q[i].pop_front());
      end
      if (ev[i] && er[i]) q[i].push_back(ed[i]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) monitor(i);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int i, input int nv, input logic [DW-1:0] base,
                        output int cyc, output int hs);
    int sent;
    int got;
    sent = 0; got = 0; cyc = 0; hs = 0;
    while (got < nv && cyc < 200) begin
      ev[i] = (sent < nv);
      ed[i] = base + DW'(sent);
      dr[i] = 1'b1;
      if (dv[i]) begin
        chk($sformatf("stream_data[%0d]", i), 32'(dd[i]), 32'(base + DW'(got)));
        got++; hs++;
      end
      if (ev[i] && er[i]) begin
        sent++; hs++;
      end
      cycle();
      cyc++;
    end
    ev[i] = 1'b0;
    dr[i] = 1'b0;
    chk($sformatf("stream_done[%0d]", i), 32'(got), 32'(nv));
  endtask

  initial begin
    int v;
    int k;
    int cyc;
    int hs;
    int nd [N];
    logic acc;

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      ev[i] = 1'b0; ed[i] = '0; dr[i] = 1'b0;
    end
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single enqueue, DEQ_READY low: latency to DEQ_VALID for L=1 and L=2.
    for (int i = 0; i < 2; i++) begin
      ev[i] = 1'b1; ed[i] = 8'h11;
      chk($sformatf("a_enq_ready[%0d]", i), 32'(er[i]), 1);
    end
    cycle();
    for (int i = 0; i < 2; i++) begin
      ev[i] = 1'b0;
      chk($sformatf("a_read_issue[%0d]", i), 32'(ben[i] & ~bwe[i]), 1);
      chk($sformatf("a_read_addr[%0d]", i), 32'(badr[i]), 0);
    end
    cycle();
    chk("a_c2_valid[0]", 32'(dv[0]), 0);
    chk("a_c2_valid[1]", 32'(dv[1]), 0);
    cycle();
    chk("a_c3_valid[0]", 32'(dv[0]), 1);
    chk("a_c3_data[0]", 32'(dd[0]), 'h11);
    chk("a_c3_valid[1]", 32'(dv[1]), 0);
    cycle();
    chk("a_c4_valid[1]", 32'(dv[1]), 1);
    chk("a_c4_data[1]", 32'(dd[1]), 'h11);
    dr[0] = 1'b1; dr[1] = 1'b1;
    cycle();
    dr[0] = 1'b0; dr[1] = 1'b0;
    chk("a_empty[0]", 32'(cnt[0]), 0);
    chk("a_empty[1]", 32'(cnt[1]), 0);

    // Fill MEMSIZE=4 with the consumer stalled: 4 in memory + 2 buffered.
    v = 1;
    for (int c = 0; c < 20; c++) begin
      ev[0] = (v <= 7);
      ed[0] = 8'(v);
      acc   = ev[0] & er[0];
      cycle();
      if (acc) v++;
    end
    ev[0] = 1'b0;
    chk("b_accepted", 32'(v - 1), 6);
    chk("b_enq_ready", 32'(er[0]), 0);
    chk("b_count", 32'(cnt[0]), 6);
    dr[0] = 1'b1;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (dv[0]) begin
        chk("b_drain_data", 32'(dd[0]), 32'(k + 1));
        k++;
      end
      cycle();
    end
    dr[0] = 1'b0;
    chk("b_drain_count", 32'(k), 6);

    // Streaming: MEMSIZE=3 wraps several times; PIPELINED=1 throughput.
    stream(2, 10, 8'h00, cyc, hs);
    stream(1, 20, 8'h40, cyc, hs);
    chk("single_port_throughput", 32'(hs <= cyc), 1);
    stream(0, 12, 8'h80, cyc, hs);

    // Reset while a read is in flight: nothing stale may come out.
    for (int i = 0; i < N; i++) begin
      ev[i] = 1'b1; ed[i] = 8'h55; dr[i] = 1'b0;
    end
    cycle();
    for (int i = 0; i < N; i++) ev[i] = 1'b0;
    cycle();
    chk("d_inflight_count[0]", 32'(cnt[0]), 1);
    chk("d_inflight_valid[0]", 32'(dv[0]), 0);
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("d_rst_count[%0d]", i), 32'(cnt[i]), 0);
      chk($sformatf("d_rst_valid[%0d]", i), 32'(dv[i]), 0);
    end
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      ev[i] = 1'b1; ed[i] = 8'hAA; dr[i] = 1'b1; nd[i] = 0;
    end
    cycle();
    for (int i = 0; i < N; i++) ev[i] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        if (dv[i]) begin
          chk($sformatf("d_data[%0d]", i), 32'(dd[i]), 'hAA);
          nd[i]++;
        end
      end
      cycle();
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("d_deq_count[%0d]", i), 32'(nd[i]), 1);
      dr[i] = 1'b0;
    end

    // Random traffic on all instances against the reference queues.
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        ev[i] = 1'($urandom_range(0, 1));
        ed[i] = 8'($urandom);
        dr[i] = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    for (int i = 0; i < N; i++) begin
      ev[i] = 1'b0; dr[i] = 1'b1;
    end
    repeat (20) cycle();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("e_final_count[%0d]", i), 32'(cnt[i]), 0);
      chk($sformatf("e_model_empty[%0d]", i), 32'(q[i].size()), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bram1_fifo_ctrl.md
BRAM1_FIFO_CTRL -- requirements
Module: bram1_fifo_ctrl

Interface
REQ-001 SHALL have parameter PIPELINED, default 0, meaning the attached BRAM1 read latency is 1 cycle (0) or 2 cycles (1).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning the BRAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, meaning the payload width.
REQ-004 SHALL have parameter MEMSIZE, default 16, meaning BRAM depth in entries, with 2 <= MEMSIZE <= 2**ADDR_WIDTH.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port ENQ_VALID, input, 1 bit: producer offers ENQ_DATA.
REQ-008 SHALL have port ENQ_DATA, input, DATA_WIDTH bits: enqueue payload.
REQ-009 SHALL have port ENQ_READY, output, 1 bit: enqueue accepted when ENQ_VALID & ENQ_READY.
REQ-010 SHALL have port DEQ_VALID, output, 1 bit: DEQ_DATA holds the head entry.
REQ-011 SHALL have port DEQ_DATA, output, DATA_WIDTH bits: head payload.
REQ-012 SHALL have port DEQ_READY, input, 1 bit: head consumed when DEQ_VALID & DEQ_READY.
REQ-013 SHALL have ports BRAM_EN, BRAM_WE (1 bit), BRAM_ADDR (ADDR_WIDTH), BRAM_DI (DATA_WIDTH), all outputs, driving the BRAM1 EN/WE/ADDR/DI inputs.
REQ-014 SHALL have port BRAM_DO, input, DATA_WIDTH bits, from the BRAM1 DO output.
REQ-015 SHALL have port COUNT, output, ADDR_WIDTH+2 bits: total entries held (memory + in-flight + output buffer).

Function
REQ-016 SHALL issue at most one BRAM operation per cycle: write (EN=1, WE=1, ADDR=wr_ptr, DI=ENQ_DATA) or read (EN=1, WE=0, ADDR=rd_ptr); otherwise EN=0.
REQ-017 SHALL issue a read when mem_count > 0 and obuf_occ + inflight < 2; a read has priority over a write in the same cycle.
REQ-018 SHALL drive ENQ_READY = !RST & (mem_count < MEMSIZE) & !read_issue, from registered state only, with no combinational path from ENQ_VALID or DEQ_READY.
REQ-019 SHALL perform the write only in a cycle where an enqueue handshake occurs.
REQ-020 SHALL capture BRAM_DO into the output buffer at the end of cycle t+L for a read issued in cycle t, where L = 1 (PIPELINED=0) or 2 (PIPELINED=1), using an L-deep valid shift pipeline.
REQ-021 SHALL use a 2-entry in-order output buffer, with DEQ_VALID = (obuf_occ > 0) and DEQ_DATA = the oldest entry; capture and dequeue in the same cycle SHALL both take effect.
REQ-022 SHALL wrap wr_ptr and rd_ptr from MEMSIZE-1 to 0; MEMSIZE is not required to be a power of two.
REQ-023 SHALL update mem_count by +1 per write and -1 per read, with no net change when neither occurs.
REQ-024 SHALL hold COUNT = mem_count + inflight + obuf_occ at all times; its maximum value is MEMSIZE+2.
REQ-025 SHALL preserve strict FIFO order with no loss or duplication under any ENQ/DEQ interleaving.
REQ-026 SHALL limit combined enqueue-plus-dequeue throughput in steady state to 1 handshake per cycle (single-port limit).

Reset
REQ-027 SHALL, while RST=1, asynchronously clear wr_ptr, rd_ptr, mem_count, the valid pipeline, and obuf_occ, and drive BRAM_EN=0, ENQ_READY=0, DEQ_VALID=0, and COUNT=0.
REQ-028 SHALL discard data from reads in flight at reset; stale BRAM_DO SHALL never reach DEQ_DATA after reset.
REQ-029 SHALL NOT clear BRAM contents or the output-buffer data registers on reset.

Structure
REQ-030 SHALL use no shared package; L and pointer limits SHALL be local constants derived from the parameters.
REQ-031 SHALL place the 2-entry output buffer in sub-module bram1_fifo_obuf.
REQ-032 SHALL NOT instantiate BRAM1; the parent wires BRAM1 to the BRAM_* ports with matching parameters.

Verification
REQ-033 SHALL cover this scenario: MEMSIZE=4, PIPELINED=0, DEQ_READY=0; enqueue 0x11 in cycle 0 -> read issued cycle 1, DEQ_VALID=1 with DEQ_DATA=0x11 from cycle 3 (cycle 4 when PIPELINED=1).
REQ-034 SHALL cover this scenario: MEMSIZE=4, DEQ_READY=0; offer 0x01..0x07 -> 6 accepted, ENQ_READY=0, COUNT=6; then drain -> 0x01..0x06 in order.
REQ-035 SHALL cover this scenario: MEMSIZE=3; stream 0x00..0x09 with DEQ_READY=1 -> output 0x00..0x09 in order, pointers wrapping 2->0 more than once.
REQ-036 SHALL cover this scenario: ENQ_VALID=1 and DEQ_READY=1 continuously for 20 values with PIPELINED=1 -> no BRAM cycle with both read and write, at most one handshake of either kind per cycle in steady state, and data intact.
REQ-037 SHALL cover this scenario: assert RST for 1 cycle while a read is in flight -> COUNT=0 and DEQ_VALID=0 immediately; after release, enqueue 0xAA -> only 0xAA is dequeued.
REQ-038 SHALL cover this scenario: random ENQ_VALID/DEQ_READY for 1000 cycles against a reference queue model -> zero mismatches, and COUNT always equals the model occupancy.
